// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
// Registered binary-to-one-hot decoder with a built-in auto-scan mode.
// Decode mode latches a select and shows its one-hot pattern one cycle later.
// Scan mode walks the active bit across all outputs, dwelling SCAN_DIV cycles
// on each index and pulsing wrap when the walk rolls over to index 0.
module onehot_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      scan_idx,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;
    // Divider needs at least one bit so SCAN_DIV=1 still has a legal counter.
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [DIV_W-1:0] div;
    logic [SEL_W-1:0] next_idx;
    logic             last_idx;

    // One-hot pattern for an index, already in output polarity.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = {OUT_W{1'b0}};
        v[idx] = 1'b1;
        if (ACTIVE_LOW != 0) begin
            v = ~v;
        end
        return v;
    endfunction

    // Index after a scan step wraps naturally modulo OUT_W.
    assign next_idx = scan_idx + 1'b1;
    assign last_idx = &scan_idx;

    // Output, index and divider registers; load beats scan step, enable-low beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= INACTIVE;
            y_valid  <= 1'b0;
            scan_idx <= {SEL_W{1'b0}};
            div      <= {DIV_W{1'b0}};
            wrap     <= 1'b0;
        end else if (!en) begin
            y       <= INACTIVE;
            y_valid <= 1'b0;
            div     <= {DIV_W{1'b0}};
            wrap    <= 1'b0;
        end else if (sel_valid) begin
            scan_idx <= sel;
            y        <= onehot(sel);
            y_valid  <= 1'b1;
            div      <= {DIV_W{1'b0}};
            wrap     <= 1'b0;
        end else if (!mode) begin
            // Decode idle: pattern and index freeze; divider re-arms for a later scan entry.
            div  <= {DIV_W{1'b0}};
            wrap <= 1'b0;
        end else begin
            y_valid <= 1'b1;
            if (div == DIV_LAST) begin
                div      <= {DIV_W{1'b0}};
                scan_idx <= next_idx;
                y        <= onehot(next_idx);
                wrap     <= last_idx;
            end else begin
                div  <= div + 1'b1;
                y    <= onehot(scan_idx);
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Testbench for onehot_scan_decoder: a default instance (SEL_W=3, SCAN_DIV=4,
// active-high) driven from a vector table, and an SEL_W=4 / ACTIVE_LOW=1 /
// SCAN_DIV=1 instance driven by a hand-written sequence.
module tb_onehot_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst1, en1, mode1, sv1;
    logic [2:0] sel1;
    logic [7:0] y1;
    logic       yv1, wrap1;
    logic [2:0] idx1;

    onehot_scan_decoder dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel_valid(sv1), .sel(sel1),
        .y(y1), .y_valid(yv1), .scan_idx(idx1), .wrap(wrap1)
    );

    // Wide, inverted, single-cycle-step instance
    logic        rst2, en2, mode2, sv2;
    logic [3:0]  sel2;
    logic [15:0] y2;
    logic        yv2, wrap2;
    logic [3:0]  idx2;

    onehot_scan_decoder #(.SEL_W(4), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sel_valid(sv2), .sel(sel2),
        .y(y2), .y_valid(yv2), .scan_idx(idx2), .wrap(wrap2)
    );

    typedef struct {
        logic        rst, en, mode, sv;
        logic [3:0]  sel;
        logic [15:0] y;
        logic        yv;
        logic [3:0]  idx;
        logic        wrap;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic m, input logic s,
                                input logic [3:0] sl, input logic [15:0] ey, input logic ev,
                                input logic [3:0] ei, input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sv = s; v.sel = sl;
        v.y = ey; v.yv = ev; v.idx = ei; v.wrap = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input int which, input vec_t v, input string tag);
        vec_t e;
        logic [15:0] ay;
        logic        av, aw;
        logic [3:0]  ai;
        if (which == 1) begin
            rst1 = v.rst; en1 = v.en; mode1 = v.mode; sv1 = v.sv; sel1 = v.sel[2:0];
        end else begin
            rst2 = v.rst; en2 = v.en; mode2 = v.mode; sv2 = v.sv; sel2 = v.sel;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (which == 1) begin
            ay = {8'h00, y1}; av = yv1; ai = {1'b0, idx1}; aw = wrap1;
        end else begin
            ay = y2; av = yv2; ai = idx2; aw = wrap2;
        end
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s.sb: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".y"},       ay,          e.y);
            chk({tag, ".y_valid"}, {15'h0, av}, {15'h0, e.yv});
            chk({tag, ".idx"},     {12'h0, ai}, {12'h0, e.idx});
            chk({tag, ".wrap"},    {15'h0, aw}, {15'h0, e.wrap});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst1 = 1'b1; en1 = 1'b1; mode1 = 1'b1; sv1 = 1'b0; sel1 = 3'd0;
        rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b0; sv2 = 1'b0; sel2 = 4'd0;

        //            rst en md sv sel   y        yv idx wrap
        // reset held two cycles in scan mode
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 0, 0, 0));
        // decode load and hold
        tbl.push_back(mk(0, 1, 0, 1, 5, 16'h0020, 1, 5, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 16'h0020, 1, 5, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 16'h0020, 1, 5, 0));
        // enable low, then re-enable in decode without a load
        tbl.push_back(mk(0, 0, 0, 0, 2, 16'h0000, 0, 5, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 0, 5, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 0, 5, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 0, 5, 0));
        // load 6, scan across 7 and wrap to 0
        tbl.push_back(mk(0, 1, 0, 1, 6, 16'h0040, 1, 6, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0040, 1, 6, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0040, 1, 6, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0040, 1, 6, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0080, 1, 7, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0080, 1, 7, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0080, 1, 7, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0080, 1, 7, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 0));
        // load on the step cycle beats the step; full dwell follows
        tbl.push_back(mk(0, 1, 1, 1, 3, 16'h0008, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0008, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0008, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0008, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0010, 1, 4, 0));
        // scan -> decode freezes, decode -> scan resumes with a fresh dwell
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 1, 4, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0010, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0010, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0010, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0020, 1, 5, 0));
        // reset mid-scan at index 5 overrides a concurrent load
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0020, 1, 5, 0));
        tbl.push_back(mk(1, 1, 1, 1, 7, 16'h0000, 0, 0, 0));
        // scan from reset, enable low, re-enable in scan mode
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 0));
        // loading index 0 never raises wrap
        tbl.push_back(mk(0, 1, 1, 1, 0, 16'h0001, 1, 0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(1, tbl[i], $sformatf("v%0d", i));
        end

        // Inverted 16-output instance, step every scan cycle
        apply(2, mk(1, 1, 1, 0, 0,  16'hFFFF, 0, 0,  0), "p_rst");
        apply(2, mk(0, 1, 0, 1, 9,  16'hFDFF, 1, 9,  0), "p_load9");
        apply(2, mk(0, 1, 1, 0, 0,  16'hFBFF, 1, 10, 0), "p_step");
        apply(2, mk(0, 1, 1, 1, 15, 16'h7FFF, 1, 15, 0), "p_load15");
        apply(2, mk(0, 1, 1, 0, 0,  16'hFFFE, 1, 0,  1), "p_wrap");
        apply(2, mk(0, 1, 1, 0, 0,  16'hFFFD, 1, 1,  0), "p_after");
        apply(2, mk(0, 0, 1, 0, 0,  16'hFFFF, 0, 1,  0), "p_dis");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Registered, parametrised binary-to-one-hot decoder with a built-in auto-scan mode. In decode mode it latches a select value and drives the one-hot pattern one cycle later. In scan mode it walks the active bit across all outputs at a programmable step rate. It is the general replacement for fixed-size combinational decoders that drive channel enables, row/column strobes and LED/mux scanning.

## Interface
Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable).
- SCAN_DIV, 4, clock cycles per scan step; legal range 1..65535.
- ACTIVE_LOW, 0, 1 inverts y so the active bit is 0 and the inactive pattern is all ones.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- mode  in  1  0 = decode, 1 = scan.
- sel_valid  in  1  sel is presented this cycle.
- sel  in  SEL_W  binary select / scan start index.
- y  out  OUT_W  registered one-hot output, polarity per ACTIVE_LOW.
- y_valid  out  1  y holds a decoded pattern.
- scan_idx  out  SEL_W  current index (registered).
- wrap  out  1  one-cycle pulse when a scan step wraps from OUT_W-1 to 0.

## Operation
- "Inactive" means all zeros, or all ones when ACTIVE_LOW=1. "onehot(i)" means bit i is active and all other bits are inactive.
- Invariant: whenever y_valid=1, y == onehot(scan_idx).
- Internal divider div has width clog2(SCAN_DIV), minimum 1.
- Per rising edge, in priority order:
  1. rst: y is inactive, y_valid=0, scan_idx=0, div=0, wrap=0.
  2. en=0: y is inactive, y_valid=0, div=0, wrap=0, scan_idx holds.
  3. sel_valid=1 (either mode): scan_idx<=sel, y<=onehot(sel), y_valid<=1, div<=0, wrap<=0. A load always beats a scan step in the same cycle.
  4. mode=0, sel_valid=0: y, y_valid and scan_idx hold; div<=0; wrap<=0.
  5. mode=1, sel_valid=0:
     - y_valid<=1.
     - If div==SCAN_DIV-1: div<=0, scan_idx<=scan_idx+1 (mod OUT_W), y<=onehot of the new index, and wrap<=1 if and only if the old index was OUT_W-1.
     - Otherwise: div<=div+1, y<=onehot(scan_idx), wrap<=0.
- Mode switch decode->scan: scanning resumes from the current scan_idx, with the full SCAN_DIV dwell starting from div=0.
- Mode switch scan->decode: y and scan_idx freeze at their current values until the next sel_valid.
- Re-enable (en 0->1), mode=0 and no sel_valid: y stays inactive and y_valid stays 0 until a sel is accepted.
- Re-enable, mode=1: the next edge drives y=onehot(scan_idx) with y_valid=1.
- SCAN_DIV=1: the index steps on every enabled scan cycle.
- A load never raises wrap, including a load of index 0.

## Timing
- Decode latency: sel/sel_valid sampled at edge N, y and y_valid valid after edge N. That is one cycle, with no combinational path from inputs to outputs.
- Scan dwell: each index is shown for exactly SCAN_DIV cycles after a load or a mode entry, and for SCAN_DIV cycles per step thereafter.
- wrap is high in the same cycle y first shows onehot(0) after a step.
- All outputs are registered and update only on clk.
- Reset mid-scan takes effect at the next edge and overrides en, mode and sel_valid.
- The enable-low effect is immediate: one edge forces y inactive.

## Test plan
- Reset: hold rst for 2 cycles with en=1, mode=1 -> y=8'h00, y_valid=0, scan_idx=0, wrap=0. Repeat with rst asserted mid-scan at index 5 -> same values next edge.
- Decode: en=1, mode=0, sel_valid=1, sel=5 -> next cycle y=8'b0010_0000, y_valid=1. Then drop sel_valid and set sel=2 -> y stays 8'b0010_0000.
- Enable: en=0 for one edge -> y=8'h00, y_valid=0. Raise en with mode=0 and no sel_valid for 3 cycles -> y stays 8'h00, y_valid=0.
- Scan wrap, SCAN_DIV=4: load sel=6, then mode=1 -> y=8'h40 for 4 cycles, 8'h80 for 4 cycles, then 8'h01 with wrap=1 for exactly one cycle.
- Load vs step: in scan mode, assert sel_valid with sel=3 on a cycle where div==3 -> y=8'h08, no step or wrap, and 8'h08 held for 4 full cycles before 8'h10 appears.
- Parameters: SEL_W=4, ACTIVE_LOW=1, SCAN_DIV=1. Reset -> y=16'hFFFF. Load sel=9 -> y=16'hFDFF. Scan -> 16'hFBFF next cycle. From index 15 the next step gives y=16'hFFFE with wrap=1.
